pipe_stage_reg: RTL and testbench

//  Parametrised elastic pipeline-stage register, successor to the fixed-field

---
 rtl/pipe_stage_reg.sv | 95 +++++++++
 tb/tb_pipe_stage_reg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: control + data bundles with valid/ready,
// optional skid entry, flush-to-bubble and a saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 96,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  logic              space;
  logic              accept;
  logic              issue;

  // With a skid entry, readiness depends only on state, breaking the out_ready path.
  always_comb begin
    if (SKID != 0) space = ~s_valid;
    else           space = ~m_valid | out_ready;
  end

  assign in_ready  = rst | (~flush & space);
  assign accept    = in_valid & in_ready;
  assign issue     = m_valid & out_ready;

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_data  <= '0;
      s_valid <= 1'b0;
      s_ctrl  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ctrl  <= '0;
    end else if (SKID != 0) begin
      // Oldest beat first: the skid entry refills the main entry before any new beat.
      if (issue && s_valid) begin
        m_ctrl  <= s_ctrl;
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else if (accept && (!m_valid || issue)) begin
        m_valid <= 1'b1;
        m_ctrl  <= in_ctrl;
        m_data  <= in_data;
      end else if (accept) begin
        s_valid <= 1'b1;
        s_ctrl  <= in_ctrl;
        s_data  <= in_data;
      end else if (issue) begin
        m_valid <= 1'b0;
      end
    end else begin
      if (accept) begin
        m_valid <= 1'b1;
        m_ctrl  <= in_ctrl;
        m_data  <= in_data;
      end else if (issue) begin
        m_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three pipe_stage_reg variants share one stimulus stream
// and are compared every cycle against a small occupancy-queue model.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 96;
  localparam int BEAT_W = CTRL_W + DATA_W;
  localparam int NDUT   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;

  logic              rdy_a, rdy_b, rdy_c;
  logic              ov_a, ov_b, ov_c;
  logic [CTRL_W-1:0] oc_a, oc_b, oc_c;
  logic [DATA_W-1:0] od_a, od_b, od_c;
  logic [15:0]       sc_a, sc_b;
  logic [3:0]        sc_c;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(16)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_ctrl(oc_a), .out_data(od_a), .stall_cnt(sc_a));

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) dut_single (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
    .out_ctrl(oc_b), .out_data(od_b), .stall_cnt(sc_b));

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready),
    .out_ctrl(oc_c), .out_data(od_c), .stall_cnt(sc_c));

  // Model: each stage is a FIFO of capacity 1 or 2 plus a saturating counter.
  bit                skidCfg [NDUT] = '{1'b1, 1'b0, 1'b1};
  int                cntMax  [NDUT] = '{65535, 65535, 15};
  logic [BEAT_W-1:0] mq      [NDUT][2];
  int                mcount  [NDUT];
  int                mstall  [NDUT];
  bit                known = 1'b0;
  int                checks = 0;
  int                errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit modelReady(input int d);
    if (rst) return 1'b1;
    if (flush) return 1'b0;
    if (skidCfg[d]) return mcount[d] < 2;
    return (mcount[d] == 0) || (out_ready == 1'b1);
  endfunction

  task automatic checkDut(input int d, input logic rdy, input logic ov,
                          input logic [CTRL_W-1:0] oc, input logic [DATA_W-1:0] od,
                          input logic [15:0] sc);
    logic [BEAT_W-1:0] head;
    head = mq[d][0];
    checkOutput($sformatf("dut%0d in_ready", d), 128'(rdy), 128'(modelReady(d)));
    if (!known) return;
    checkOutput($sformatf("dut%0d out_valid", d), 128'(ov), 128'(mcount[d] > 0));
    checkOutput($sformatf("dut%0d out_ctrl", d), 128'(oc),
                (mcount[d] > 0) ? 128'(head[BEAT_W-1:DATA_W]) : 128'(0));
    if (mcount[d] > 0)
      checkOutput($sformatf("dut%0d out_data", d), 128'(od), 128'(head[DATA_W-1:0]));
    checkOutput($sformatf("dut%0d stall_cnt", d), 128'(sc), 128'(mstall[d]));
  endtask

  task automatic modelUpdate(input int d);
    bit rdy;
    bit iss;
    rdy = modelReady(d);
    iss = (mcount[d] > 0) && (out_ready == 1'b1);
    if (rst) begin
      mcount[d] = 0;
      mstall[d] = 0;
      return;
    end
    if (in_valid && !rdy && !flush && mstall[d] < cntMax[d]) mstall[d]++;
    if (flush) begin
      mcount[d] = 0;
      return;
    end
    if (iss) begin
      mq[d][0] = mq[d][1];
      mcount[d]--;
    end
    if (in_valid && rdy) begin
      mq[d][mcount[d]] = {in_ctrl, in_data};
      mcount[d]++;
    end
  endtask

  // One cycle: drive inputs, check all outputs, advance the model across the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] dt,
                               input logic ordy, output bit taken);
    rst = r; flush = f; in_valid = v; in_ctrl = c; in_data = dt; out_ready = ordy;
    #1;
    checkDut(0, rdy_a, ov_a, oc_a, od_a, sc_a);
    checkDut(1, rdy_b, ov_b, oc_b, od_b, sc_b);
    checkDut(2, rdy_c, ov_c, oc_c, od_c, {12'b0, sc_c});
    taken = v && !r && modelReady(0);
    for (int d = 0; d < NDUT; d++) modelUpdate(d);
    if (r) known = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetState();
    checkOutput("reset out_valid", 128'({ov_a, ov_b, ov_c}), 128'(0));
    checkOutput("reset out_ctrl", 128'({oc_a, oc_b, oc_c}), 128'(0));
    checkOutput("reset out_data a", 128'(od_a), 128'(0));
    checkOutput("reset out_data b", 128'(od_b), 128'(0));
    checkOutput("reset out_data c", 128'(od_c), 128'(0));
    checkOutput("reset stall_cnt", 128'({sc_a, sc_b, sc_c}), 128'(0));
    checkOutput("reset in_ready", 128'({rdy_a, rdy_b, rdy_c}), 128'(3'b111));
  endtask

  function automatic logic [DATA_W-1:0] randData();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit taken;
    int k;
    logic              curValid;
    logic [CTRL_W-1:0] curCtrl;
    logic [DATA_W-1:0] curData;
    logic              r, f, o;

    for (int d = 0; d < NDUT; d++) begin
      mcount[d] = 0;
      mstall[d] = 0;
    end

    $display("[TB] reset");
    applyStimulus(1, 0, 0, '0, '0, 0, taken);
    applyStimulus(1, 0, 0, '0, '0, 0, taken);
    checkResetState();
    applyStimulus(0, 0, 0, '0, '0, 0, taken);

    $display("[TB] streaming with out_ready=1");
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 1, 4'hA, DATA_W'(i), 1, taken);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, '0, 1, taken);

    $display("[TB] back-pressure with skid");
    k = 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, (k <= 3), 4'h5, DATA_W'(k), 0, taken);
      if (taken) k++;
    end
    checkOutput("held stall count", 128'(sc_a), 128'(6));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, (k <= 3), 4'h5, DATA_W'(k), 1, taken);
      if (taken) k++;
    end

    $display("[TB] flush with stage full");
    k = 0;
    for (int i = 0; i < 6 && k < 2; i++) begin
      applyStimulus(0, 0, 1, 4'hF, DATA_W'(100 + k), 0, taken);
      if (taken) k++;
    end
    applyStimulus(0, 1, 1, 4'hF, DATA_W'(200), 1, taken);
    checkOutput("post-flush out_valid", 128'(ov_a), 128'(0));
    checkOutput("post-flush out_ctrl", 128'(oc_a), 128'(0));
    applyStimulus(0, 0, 0, '0, '0, 0, taken);

    $display("[TB] simultaneous accept and issue");
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 1, CTRL_W'($urandom), randData(), 1, taken);
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 0, 1, CTRL_W'($urandom), randData(), logic'(i % 2), taken);

    $display("[TB] reset mid-stream");
    applyStimulus(1, 0, 1, 4'h3, randData(), 0, taken);
    applyStimulus(1, 0, 1, 4'h3, randData(), 1, taken);
    checkResetState();

    $display("[TB] stall counter saturation");
    curData = randData();
    for (int i = 0; i < 22; i++) begin
      applyStimulus(0, 0, 1, 4'h7, curData, 0, taken);
      if (taken) curData = randData();
    end
    checkOutput("stall_cnt saturated", 128'(sc_c), 128'(15));
    checkOutput("stall_cnt wide", 128'(sc_a), 128'(20));
    applyStimulus(0, 0, 1, 4'h7, curData, 0, taken);
    checkOutput("stall_cnt holds", 128'(sc_c), 128'(15));

    $display("[TB] randomized traffic");
    curValid = 1'b0;
    curCtrl  = '0;
    curData  = '0;
    for (int i = 0; i < 600; i++) begin
      if (!curValid) begin
        curValid = ($urandom_range(0, 3) != 0);
        curCtrl  = CTRL_W'($urandom);
        curData  = randData();
      end
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 15) == 0);
      o = ($urandom_range(0, 2) != 0);
      applyStimulus(r, f, curValid, curCtrl, curData, o, taken);
      if (taken) curValid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
